// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states,
// instruction field positions and opcode encodings.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        DONE
    } state_t;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 11;
    localparam int RS_MSB  = 10;
    localparam int RS_LSB  = 9;
    localparam int IMM_MSB = 7;

    localparam logic [2:0] LOAD  = 3'b000;
    localparam logic [2:0] MOVE  = 3'b001;
    localparam logic [2:0] ADD   = 3'b010;
    localparam logic [2:0] SUB   = 3'b011;
    localparam logic [2:0] AND   = 3'b100;
    localparam logic [2:0] OR    = 3'b101;
    localparam logic [2:0] XOR   = 3'b110;
    localparam logic [2:0] STORE = 3'b111;

endpackage

// File: rtl/seq_prog_ram.sv
// Program RAM: single write port, synchronous read with enable. Only the read
// register is reset; the array contents survive reset.
module seq_prog_ram #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register doubles as the presented instruction, so it holds
    // whenever re is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction-issue front end: loadable program RAM, PC stepping and a
// valid/ready instruction port. Define SEQ_LOOP_EN to loop the program forever.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               start,
    input  logic               stop,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [2:0]         opCode,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic [7:0]         imm,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done
);

    state_t               state;
    state_t               state_next;
    logic [ADDR_W:0]      len_latched;
    logic [ADDR_W:0]      pc_inc;
    logic                 last_instr;
    logic                 accept;
    logic                 launch;
    logic                 ram_re;
    logic [INSTR_W-1:0]   rdata;
    logic                 unused_reserved;

    // Compare at ADDR_W+1 bits so a full-depth program does not alias to 0.
    assign pc_inc     = {1'b0, pc} + (ADDR_W+1)'(1);
    assign last_instr = (pc_inc == len_latched);
    assign accept     = (state == ISSUE) && instr_ready && !stop;
    assign launch     = ((state == IDLE) || (state == DONE)) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (prog_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                state_next = stop ? DONE : ISSUE;
            end
            ISSUE: begin
                if (stop) begin
                    state_next = DONE;
                end else if (instr_ready) begin
`ifdef SEQ_LOOP_EN
                    state_next = FETCH;
`else
                    state_next = last_instr ? DONE : FETCH;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        instr_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        ram_re      = 1'b0;
        unique case (state)
            FETCH: begin
                busy   = 1'b1;
                ram_re = 1'b1;
            end
            ISSUE: begin
                busy        = 1'b1;
                instr_valid = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            len_latched <= '0;
        end else if (launch) begin
            pc          <= '0;
            len_latched <= prog_len;
        end else if (accept) begin
            if (!last_instr) begin
                pc <= pc_inc[ADDR_W-1:0];
            end else begin
`ifdef SEQ_LOOP_EN
                pc <= '0;
`else
                pc <= pc;
`endif
            end
        end
    end

    seq_prog_ram #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (ram_re),
        .raddr (pc),
        .rdata (rdata)
    );

    assign opCode          = rdata[OPC_MSB:OPC_LSB];
    assign rd              = rdata[RD_MSB:RD_LSB];
    assign rs              = rdata[RS_MSB:RS_LSB];
    assign imm             = rdata[IMM_MSB:0];
    assign unused_reserved = rdata[8];

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected issues are queued when a run
// starts and checked by a monitor on every accepted instruction.
module tb_instr_sequencer;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [2:0]  opCode;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  imm;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    typedef struct {
        logic [3:0]  pc;
        logic [15:0] word;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] mem_model [16];
    int          checks = 0;
    int          errors = 0;

    instr_sequencer #(.ADDR_W(4), .INSTR_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .start       (start),
        .stop        (stop),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opCode      (opCode),
        .rd          (rd),
        .rs          (rs),
        .imm         (imm),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] fields(input logic [15:0] w);
        return {w[15:13], w[12:11], w[10:9], w[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready && !stop) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_accept actual pc=%0d expected no issue", pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue", {13'd0, pc, opCode, rd, rs, imm}, {13'd0, mon_e.pc, fields(mon_e.word)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input logic [3:0] a, input logic [15:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we = 1'b0;
        mem_model[a] = d;
    endtask

    task automatic start_run(input int len);
        prog_len = 5'(len);
        start = 1'b1;
        for (int i = 0; i < len; i++) exp_q.push_back('{pc: 4'(i), word: mem_model[i]});
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit rnd);
        int n;
        n = 0;
        while (n < budget) begin
            tick();
            instr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (done) break;
            n++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem_model[i] = '0;
        tick();
        tick();
        @(negedge clk);
        check("reset_outputs", {instr_valid, busy, done, pc, opCode, rd, rs, imm}, 0);
        tick();
        reset = 1'b0;

        write_mem(4'd0, 16'h0205);
        write_mem(4'd1, 16'h4A00);
`ifdef SEQ_LOOP_EN
        write_mem(4'd2, 16'hE1C3);
        instr_ready = 1'b1;
        start_run(3);
        exp_q.push_back('{pc: 4'd0, word: mem_model[0]});
        exp_q.push_back('{pc: 4'd1, word: mem_model[1]});
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("loop_drained", exp_q.size(), 0);
        check("loop_no_done", {31'd0, done}, 0);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        check("loop_stop_done", {instr_valid, done}, 2'b01);
`else
        // Basic two-instruction run with ready tied high.
        instr_ready = 1'b1;
        start_run(2);
        @(negedge clk);
        check("first_c1_valid", {31'd0, instr_valid}, 0);
        tick();
        @(negedge clk);
        check("first_c2_valid", {31'd0, instr_valid}, 1);
        check("first_op", opCode, LOAD);
        tick();
        tick();
        @(negedge clk);
        check("second_op", opCode, ADD);
        run_until_done(20, 1'b0);

        // Backpressure: fields held while ready is low.
        instr_ready = 1'b0;
        start_run(2);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold", {12'd0, instr_valid, pc, fields(opCode == opCode ? {opCode, rd, rs, 1'b0, imm} : 16'h0)},
                  {12'd0, 1'b1, 4'd0, fields(mem_model[0])});
            tick();
        end
        instr_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_advance", {instr_valid, pc}, {1'b0, 4'd1});
        run_until_done(20, 1'b0);

        // Full depth, random program and random backpressure.
        for (int i = 0; i < 16; i++) write_mem(4'(i), 16'($urandom));
        start_run(16);
        run_until_done(400, 1'b1);
        check("full_no_wrap", {done, pc}, {1'b1, 4'd15});

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) write_mem(4'(i), 16'($urandom));
            start_run(int'($urandom_range(1, 16)));
            run_until_done(400, 1'b1);
        end

        // stop together with ready in ISSUE at pc=1.
        instr_ready = 1'b0;
        start_run(4);
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        instr_ready = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        instr_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("stop_state", {instr_valid, done, pc}, {1'b0, 1'b1, 4'd1});

        // Write while busy must be dropped; rerun reads the old word.
        start_run(4);
        prog_we = 1'b1;
        prog_addr = 4'd0;
        prog_data = ~mem_model[0];
        tick();
        prog_we = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        exp_q.delete();
        instr_ready = 1'b1;
        start_run(1);
        run_until_done(20, 1'b0);
`endif

        // Synchronous reset while an instruction is presented.
        instr_ready = 1'b0;
        start_run(3);
        tick();
        @(negedge clk);
        check("pre_reset_valid", {31'd0, instr_valid}, 1);
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("mid_reset_outputs", {instr_valid, busy, done, pc, opCode, rd, rs, imm}, 0);
        reset = 1'b0;
        exp_q.delete();

        // Zero-length program goes straight to DONE.
        instr_ready = 1'b1;
        start_run(0);
        @(negedge clk);
        check("len0_done", {instr_valid, busy, done}, 3'b001);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check("len0_no_valid", {31'd0, instr_valid}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction-issue front end for the 8-bit processor, and the initiator side of the 3-bit opCode interface that the control decoder consumes.
- Holds a small loadable program RAM, steps a program counter, and presents one decoded-ready instruction at a time to the datapath/control unit over a valid/ready handshake.
- Sits between the host/test loader and the control-unit/register-file datapath.

Parameters:
- ADDR_W, 4, program-counter and program-RAM address width (depth = 2**ADDR_W).
- INSTR_W, 16, instruction word width; fixed field layout below, so must be 16.

Ports:
- clk, input, 1, single system clock, rising edge.
- reset, input, 1, synchronous, active-high.
- prog_we, input, 1, program RAM write strobe (honoured only in IDLE/DONE).
- prog_addr, input, ADDR_W, program RAM write address.
- prog_data, input, INSTR_W, program RAM write data.
- prog_len, input, ADDR_W+1, number of instructions to run (0..2**ADDR_W); sampled on start.
- start, input, 1, one-cycle pulse that begins execution from PC=0.
- stop, input, 1, abort request; forces DONE at next edge.
- instr_valid, output, 1, instruction fields below are valid.
- instr_ready, input, 1, datapath accepts the instruction this cycle.
- opCode, output, 3, instruction bits [15:13].
- rd, output, 2, destination register, bits [12:11].
- rs, output, 2, source register, bits [10:9].
- imm, output, 8, immediate, bits [7:0]; bit [8] reserved, ignored.
- pc, output, ADDR_W, address of the instruction currently presented.
- busy, output, 1, high in FETCH or ISSUE.
- done, output, 1, high in DONE.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high, named reset. Reset has priority over every other input.
- Reset values: state=IDLE, pc=0, instr_valid=0, opCode/rd/rs/imm=0, busy=0, done=0. Program RAM contents are not reset.
- States:
  - IDLE: start and prog_len!=0 -> FETCH with pc=0. start and prog_len==0 -> DONE.
  - FETCH: one cycle; synchronous RAM read of mem[pc], registered into the output fields -> ISSUE.
  - ISSUE: instr_valid=1. Outputs are held stable until instr_ready.
    - On instr_valid & instr_ready: if pc+1 == len_latched -> DONE; else pc <= pc+1 -> FETCH.
  - DONE: done=1, instr_valid=0. start -> restart as in IDLE (prog_len re-sampled).
- Throughput: 2 cycles per instruction minimum; start-to-first-valid latency is 2 cycles.
- Handshake rules:
  - instr_valid never drops without acceptance, except on stop or reset.
  - Fields do not change while valid=1 and ready=0.
  - ready while valid=0 has no effect.
- stop: from FETCH or ISSUE -> DONE next edge, instr_valid cleared, pc holds. In IDLE/DONE it is ignored.
- Simultaneous events:
  - stop and start together in IDLE: start wins.
  - stop and handshake together in ISSUE: stop wins; the instruction counts as not issued.
- prog_we: ignored while busy. When not busy, write mem[prog_addr] <= prog_data at the edge.
- Arithmetic: len_latched is ADDR_W+1 bits. The pc+1 compare is done at ADDR_W+1 bits, so prog_len = 2**ADDR_W runs the full RAM without wrap aliasing.
- Opcodes are passed through unmodified; the sequencer does not interpret them.

Optional Feature:
- SEQ_LOOP_EN defined: on the last accepted instruction, pc wraps to 0 and the FSM returns to FETCH instead of DONE. It runs until stop or reset, and done is only asserted via stop.
- SEQ_LOOP_EN undefined: behaviour as above (single pass to DONE).

Decomposition:
- Package seq_pkg:
  - state enum (IDLE, FETCH, ISSUE, DONE);
  - field position constants OPC_MSB=15, OPC_LSB=13, RD_MSB=12, RD_LSB=11, RS_MSB=10, RS_LSB=9, IMM_MSB=7;
  - opcode constants LOAD=000, MOVE=001, ADD=010, SUB=011, AND=100, OR=101, XOR=110, STORE=111.
- One sub-module: seq_prog_ram (single write port, synchronous read, 2**ADDR_W x INSTR_W).

Test Plan:
- Reset then load mem[0]=16'h0205, mem[1]=16'h4A00, prog_len=2, pulse start, ready tied 1:
  - valid first high 2 cycles after start, with opCode=000, rd=0, rs=1, imm=05;
  - next instruction has opCode=010, rd=1, rs=1;
  - done rises after the second accept.
- Backpressure: ready=0 for 5 cycles during ISSUE -> opCode/rd/rs/imm/pc stable and valid held; the accept on the 6th cycle advances pc.
- prog_len=0 with start -> done=1 next cycle, and instr_valid never asserts.
- Full depth: prog_len=16 (ADDR_W=4) -> 16 accepts observed with pc 0..15, then DONE with no wrap.
- stop asserted in ISSUE together with ready -> DONE next cycle, valid=0, pc unchanged. A prog_we while busy leaves memory unchanged, checked by a rerun.
- Synchronous reset asserted mid-ISSUE -> next edge state=IDLE, all outputs 0. With SEQ_LOOP_EN and prog_len=3 -> pc sequence 0,1,2,0,1 until stop.
